xmos_stream_mux: RTL and testbench
==================================

# xmos_stream_mux

Parametrised N-channel capture multiplexer feeding the 8-bit XMOS parallel link path. Each channel writes words into its own FIFO. A round-robin arbiter drains the FIFOs into a single registered valid/ready output stream. Every output word carries its channel number and a per-channel drop count. The block replaces the fixed single-channel FIFO-plus-overflow-counter arrangement, so ULPI capture, SDRAM status and future sources can share one link.

## Interface
- NCH, 2: number of input channels, 1..8.
- DW, 8: payload width per word.
- DEPTH, 16: per-channel FIFO depth in words; power of 2, at least 2.
- OVW, 7: drop-counter width.
- CHW, derived, max(1, clog2(NCH)): channel-id width. Not overridable.
- clk  input  1  single clock for all logic.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  NCH  per-channel write strobe. There is no back-pressure; words arriving while full are dropped.
- in_data  input  NCH*DW  channel c occupies bits [c*DW +: DW].
- ch_enable  input  NCH  channel enable mask. A disabled channel ignores in_valid and is skipped by the arbiter.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  sink accepts the word on this edge when out_valid is also high.
- out_data  output  CHW+OVW+DW  {channel id, drop count, payload}, MSB first.
- ch_full  output  NCH  per-channel FIFO full flag (registered).
- ch_empty  output  NCH  per-channel FIFO empty flag (registered).

## Operation
- Reset, asynchronous and effective immediately:
  - all FIFOs empty;
  - drop counters 0;
  - out_valid=0, out_data=0;
  - ch_full=0, ch_empty=all 1;
  - round-robin pointer points at channel 0.
- FIFO write: occurs when in_valid[c] && ch_enable[c] && (count<DEPTH || pop of c on the same edge). A pop and a write of a full FIFO on the same edge both occur; the count stays at DEPTH.
- Drop: occurs when in_valid[c] && ch_enable[c] and the write condition fails. drop_cnt[c] increments and saturates at 2^OVW-1.
- Output register load: occurs when (!out_valid || out_ready) and at least one enabled, non-empty channel exists.
  - The grant goes to the first such channel at or after the RR pointer, wrapping modulo NCH.
  - The head word is popped and loaded.
  - The RR pointer moves to grant+1 mod NCH.
- Drop count in the loaded word: the loaded word carries drop_cnt[grant] at that edge, and the counter is cleared on the same edge. A drop on that same edge sets the counter to 1 instead of 0.
- Sink stall: out_valid && !out_ready holds out_data stable and out_valid high, with no pop. A channel's enable is sampled each cycle; disabling it does not retract a word already in the output register.
- Idle: when no load occurs, out_valid <= out_valid && !out_ready.
- FIFO contents are preserved while a channel is disabled.

## Timing
- Latency: a word written at edge k into an empty FIFO, with the output register free, appears with out_valid=1 after edge k+1.
- Throughput: 1 word per clock with out_ready held high. There is no bubble between back-to-back accepts, including grant changes across channels.
- Flags: ch_full and ch_empty reflect FIFO count after each edge.
- Fairness: with all channels continuously non-empty, each channel is granted exactly once every NCH loads.
- Pointers: FIFO read and write pointers are log2(DEPTH)+1 bits wide and wrap naturally. The count is the pointer difference.

## Test plan
- Single word: NCH=2, DW=8, OVW=7 (CHW=1, out_data 16 bits). Write 0xA5 on ch1 at edge k, out_ready=1. Required: out_valid high after k+1, out_data=16'h80A5 (ch=1, drop=0), out_valid low after k+2.
- Back-pressure: fill ch0 with 0x01..0x04, out_ready=0 for 10 cycles. Required: out_data stays 0x0001 and ch0 count stays 3 throughout. Release out_ready; required: 0x01..0x04 in order on 4 consecutive edges.
- Overflow: DEPTH=4, out_ready=0, 9 writes to ch0.
  - Required after the writes: the output register holds word 1, the FIFO holds words 2-5, ch_full=1, drop count=4.
  - Release out_ready. Required: the first word loaded after word 1 (word 2) carries drop=4; subsequent words carry drop=0.
- Saturation: OVW=3, 12 drops on ch0. Required: the next ch0 word carries drop=7.
- Round-robin: NCH=4, all channels pre-filled, out_ready=1. Required: channel ids 0,1,2,3,0,1… After ch2 is disabled: 0,1,3,0,…
- Reset mid-stream: assert rst_n=0 between edges while out_valid=1 and FIFOs are non-empty. Required: out_valid=0 and ch_empty=all 1 immediately, without waiting for a clock edge, and no stale word emitted after release.

Source files
------------

// File: rtl/xmos_stream_mux.sv
// N-channel capture multiplexer: per-channel FIFOs with saturating drop counters,
// drained round-robin into one registered valid/ready stream tagged {ch, drops, data}.
module xmos_stream_mux #(
    parameter int NCH   = 2,
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int OVW   = 7,
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         in_valid,
    input  logic [NCH*DW-1:0]      in_data,
    input  logic [NCH-1:0]         ch_enable,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CHW+OVW+DW-1:0]  out_data,
    output logic [NCH-1:0]         ch_full,
    output logic [NCH-1:0]         ch_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DW-1:0]          mem_q   [NCH][DEPTH];
    logic [PW-1:0]          wptr_q  [NCH];
    logic [PW-1:0]          wptr_d  [NCH];
    logic [PW-1:0]          rptr_q  [NCH];
    logic [PW-1:0]          rptr_d  [NCH];
    logic [PW-1:0]          cnt     [NCH];
    logic [PW-1:0]          cnt_d   [NCH];
    logic [OVW-1:0]         drop_q  [NCH];
    logic [OVW-1:0]         drop_d  [NCH];
    logic [NCH-1:0]         full_q, full_d;
    logic [NCH-1:0]         empty_q, empty_d;
    logic                   out_valid_q, out_valid_d;
    logic [CHW+OVW+DW-1:0]  out_data_q, out_data_d;
    logic [CHW-1:0]         rr_q, rr_d;

    logic [NCH-1:0]         elig, pop, wr, drop_ev;
    logic [CHW-1:0]         grant, cand;
    logic                   found, load;

    always_comb begin
        for (int unsigned c = 0; c < NCH; c++) begin
            cnt[c]  = wptr_q[c] - rptr_q[c];
            elig[c] = ch_enable[c] && (cnt[c] != '0);
        end
    end

    // First eligible channel at or after the RR pointer, wrapping modulo NCH.
    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            cand = CHW'((32'(rr_q) + i) % NCH);
            if (!found && elig[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
        load = (!out_valid_q || out_ready) && found;
    end

    always_comb begin
        for (int unsigned c = 0; c < NCH; c++) begin
            pop[c]     = load && (grant == CHW'(c));
            wr[c]      = in_valid[c] && ch_enable[c] && ((cnt[c] != PW'(DEPTH)) || pop[c]);
            drop_ev[c] = in_valid[c] && ch_enable[c] && !wr[c];
            wptr_d[c]  = wptr_q[c] + PW'(wr[c]);
            rptr_d[c]  = rptr_q[c] + PW'(pop[c]);
            cnt_d[c]   = wptr_d[c] - rptr_d[c];
            full_d[c]  = (cnt_d[c] == PW'(DEPTH));
            empty_d[c] = (cnt_d[c] == '0);
            // The counter value travels with the popped word, so a pop restarts it.
            if (pop[c]) begin
                drop_d[c] = drop_ev[c] ? OVW'(1) : '0;
            end else if (drop_ev[c] && (drop_q[c] != '1)) begin
                drop_d[c] = drop_q[c] + OVW'(1);
            end else begin
                drop_d[c] = drop_q[c];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        rr_d        = rr_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = {grant, drop_q[grant], mem_q[grant][rptr_q[grant][AW-1:0]]};
            rr_d        = (32'(grant) == NCH - 1) ? '0 : grant + CHW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                drop_q[c] <= '0;
            end
            full_q      <= '0;
            empty_q     <= '1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            rr_q        <= '0;
        end else begin
            for (int unsigned c = 0; c < NCH; c++) begin
                wptr_q[c] <= wptr_d[c];
                rptr_q[c] <= rptr_d[c];
                drop_q[c] <= drop_d[c];
            end
            full_q      <= full_d;
            empty_q     <= empty_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            rr_q        <= rr_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < NCH; c++) begin
            if (wr[c]) begin
                mem_q[c][wptr_q[c][AW-1:0]] <= in_data[c*DW +: DW];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign ch_full   = full_q;
    assign ch_empty  = empty_q;

endmodule

// File: tb/tb_xmos_stream_mux.sv
// Scoreboard bench for xmos_stream_mux: a queue-based reference model predicts each
// loaded word; a negedge monitor compares output and flags against it.
module tb_xmos_stream_mux;

    localparam int NCH   = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int OVW   = 3;
    localparam int CHW   = 2;
    localparam int OW    = CHW + OVW + DW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    in_valid;
    logic [NCH*DW-1:0] in_data;
    logic [NCH-1:0]    ch_enable;
    logic              out_valid;
    logic              out_ready;
    logic [OW-1:0]     out_data;
    logic [NCH-1:0]    ch_full;
    logic [NCH-1:0]    ch_empty;

    always #5 clk = ~clk;

    xmos_stream_mux #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .OVW(OVW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .ch_enable (ch_enable),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ch_full   (ch_full),
        .ch_empty  (ch_empty)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [OW-1:0] exp_q [$];
    logic [DW-1:0] m_fifo [NCH][$];
    int            m_drop [NCH];
    bit            m_ov;
    int            m_rr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_fifo[c].delete();
            m_drop[c] = 0;
        end
        m_ov = 1'b0;
        m_rr = 0;
        exp_q.delete();
    endtask

    // Effect of one clock edge, stated directly from the channel/arbiter rules.
    task automatic model(input logic [NCH-1:0] v, input logic [NCH*DW-1:0] d,
                         input logic [NCH-1:0] en, input logic rdy);
        int g;
        g = -1;
        if (!m_ov || rdy) begin
            for (int i = 0; i < NCH; i++) begin
                int c;
                c = (m_rr + i) % NCH;
                if (g < 0 && en[c] && m_fifo[c].size() > 0) g = c;
            end
        end
        if (g >= 0) begin
            logic [DW-1:0] w;
            w = m_fifo[g].pop_front();
            exp_q.push_back({CHW'(g), OVW'(m_drop[g]), w});
            m_drop[g] = 0;
            m_rr = (g + 1) % NCH;
            m_ov = 1'b1;
        end else begin
            m_ov = m_ov && !rdy;
        end
        for (int c = 0; c < NCH; c++) begin
            if (v[c] && en[c]) begin
                if (m_fifo[c].size() < DEPTH) m_fifo[c].push_back(d[c*DW +: DW]);
                else if (m_drop[c] < (1 << OVW) - 1) m_drop[c]++;
            end
        end
    endtask

    task automatic step(input logic [NCH-1:0] v, input logic [NCH*DW-1:0] d,
                        input logic [NCH-1:0] en, input logic rdy);
        in_valid  = v;
        in_data   = d;
        ch_enable = en;
        out_ready = rdy;
        @(posedge clk);
        #1;
        model(v, d, en, rdy);
    endtask

    task automatic wr1(input int ch, input logic [DW-1:0] val, input logic rdy);
        logic [NCH*DW-1:0] d;
        d = '0;
        d[ch*DW +: DW] = val;
        step(NCH'(1) << ch, d, '1, rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step('0, '0, '1, rdy);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (out_valid && exp_q.size() != 0) begin
                check("out_data", 32'(out_data), 32'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
            for (int c = 0; c < NCH; c++) begin
                check("ch_full", 32'(ch_full[c]), 32'(m_fifo[c].size() == DEPTH));
                check("ch_empty", 32'(ch_empty[c]), 32'(m_fifo[c].size() == 0));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = '0; in_data = '0; ch_enable = '1; out_ready = 1'b0;
        model_reset();
        #12;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_ch_full", 32'(ch_full), 32'h0);
        check("rst_ch_empty", 32'(ch_empty), 32'hF);
        @(posedge clk); #1; rst_n = 1'b1;

        // Single word on ch1: visible one edge after the write.
        wr1(1, 8'hA5, 1'b1);
        check("lat_valid_k", 32'(out_valid), 32'h0);
        check("lat_empty_k", 32'(ch_empty), 32'hD);
        idle(1, 1'b1);
        check("lat_valid_k1", 32'(out_valid), 32'h1);
        check("lat_data_k1", 32'(out_data), 32'h08A5);
        idle(1, 1'b1);
        check("lat_valid_k2", 32'(out_valid), 32'h0);

        // Back-pressure: output holds word 1 while the FIFO keeps 2..4.
        for (int i = 1; i <= 4; i++) wr1(0, 8'(i), 1'b0);
        idle(10, 1'b0);
        check("bp_hold_data", 32'(out_data), 32'h0001);
        idle(6, 1'b1);

        // Overflow: 9 writes into a depth-4 FIFO behind a stalled output.
        for (int i = 1; i <= 9; i++) wr1(0, 8'(i), 1'b0);
        check("ovf_full", 32'(ch_full[0]), 32'h1);
        check("ovf_hold", 32'(out_data), 32'h0001);
        idle(1, 1'b1);
        check("ovf_drop4", 32'(out_data), 32'h0402);
        idle(6, 1'b1);

        // Saturation: 12 drops on a 3-bit counter.
        for (int i = 1; i <= 17; i++) wr1(0, 8'(i), 1'b0);
        idle(1, 1'b1);
        check("sat_drop7", 32'(out_data), 32'h0702);
        idle(6, 1'b1);

        // Round-robin with all channels busy, then with ch2 disabled.
        for (int i = 0; i < 5; i++) step('1, $urandom, '1, 1'b0);
        for (int i = 0; i < 8; i++) step('1, $urandom, '1, 1'b1);
        for (int i = 0; i < 8; i++) step('1, $urandom, 4'b1011, 1'b1);
        idle(20, 1'b1);

        // Random traffic, enables and back-pressure.
        for (int i = 0; i < 1500; i++) begin
            logic [NCH-1:0] en;
            en = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '1;
            step(NCH'($urandom), $urandom, en, $urandom_range(0, 3) != 0);
        end

        // Reset between edges while a word is pending and FIFOs hold data.
        for (int i = 0; i < 4; i++) step('1, $urandom, '1, 1'b0);
        in_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_empty", 32'(ch_empty), 32'hF);
        check("mid_rst_full", 32'(ch_full), 32'h0);
        check("mid_rst_data", 32'(out_data), 32'h0);
        model_reset();
        @(posedge clk); #1; rst_n = 1'b1;
        idle(5, 1'b1);

        idle(30, 1'b1);
        check("final_empty", 32'(ch_empty), 32'hF);
        check("final_valid", 32'(out_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
